// File: rtl/ram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_bist                                                     |
// | Description : March-style RAM self-test: write pattern, read back, count   |
// |               mismatches. Define RAM_BIST_INV_PASS_EN to add a second      |
// |               pass with the inverted pattern.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_bist #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wrt,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [6:0]        err_cnt
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WRITE     = 3'd1;
    localparam logic [2:0] c_READ      = 3'd2;
    localparam logic [2:0] c_FLUSH     = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;
`ifdef RAM_BIST_INV_PASS_EN
    localparam logic [2:0] c_WRITE_INV = 3'd5;
    localparam logic [2:0] c_READ_INV  = 3'd6;
`endif

    localparam logic [DATA_W-1:0] c_SEED      = DATA_W'(8'hA5);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [6:0]        c_ERR_MAX   = 7'd127;

    function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W-1:0] a);
        return c_SEED ^ DATA_W'(a);
    endfunction

    logic [2:0]        r_state;
    logic              r_cmp_vld;
    logic [ADDR_W-1:0] r_cmp_addr;
`ifdef RAM_BIST_INV_PASS_EN
    logic              r_cmp_inv;
    logic              r_inv;
`endif

    logic [DATA_W-1:0] w_exp;
    logic              w_mismatch;
    logic [6:0]        w_err_next;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_inc;

    // Read data arrives one cycle after the read strobe, so the compare uses the
    // address captured on the previous edge.
`ifdef RAM_BIST_INV_PASS_EN
    assign w_exp = r_cmp_inv ? ~f_pat(r_cmp_addr) : f_pat(r_cmp_addr);
`else
    assign w_exp = f_pat(r_cmp_addr);
`endif
    assign w_mismatch = r_cmp_vld && (mem_dout != w_exp);
    assign w_err_next = (w_mismatch && (err_cnt != c_ERR_MAX)) ? err_cnt + 7'd1 : err_cnt;
    assign w_last     = (mem_addr == c_LAST_ADDR);
    assign w_addr_inc = mem_addr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            r_cmp_inv  <= 1'b0;
            r_inv      <= 1'b0;
`endif
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_wrt    <= 1'b0;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            err_cnt    <= '0;
        end else begin
            r_cmp_vld <= 1'b0;
            err_cnt   <= w_err_next;
            // fail_addr latches only while the count is still zero
            if (w_mismatch && (err_cnt == 7'd0)) begin
                fail_addr <= r_cmp_addr;
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state   <= c_WRITE;
                        mem_addr  <= c_ZERO_ADDR;
                        mem_din   <= f_pat(c_ZERO_ADDR);
                        mem_wrt   <= 1'b1;
                        mem_rd    <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
`ifdef RAM_BIST_INV_PASS_EN
                        r_inv     <= 1'b0;
`endif
                    end
                end

                c_WRITE: begin
                    if (w_last) begin
                        r_state  <= c_READ;
                        mem_addr <= c_ZERO_ADDR;
                        mem_din  <= '0;
                        mem_wrt  <= 1'b0;
                        mem_rd   <= 1'b1;
                    end else begin
                        mem_addr <= w_addr_inc;
                        mem_din  <= f_pat(w_addr_inc);
                    end
                end

                c_READ: begin
                    r_cmp_vld  <= 1'b1;
                    r_cmp_addr <= mem_addr;
`ifdef RAM_BIST_INV_PASS_EN
                    r_cmp_inv  <= 1'b0;
`endif
                    if (w_last) begin
                        r_state <= c_FLUSH;
                        mem_rd  <= 1'b0;
                    end else begin
                        mem_addr <= w_addr_inc;
                    end
                end

`ifdef RAM_BIST_INV_PASS_EN
                c_WRITE_INV: begin
                    if (w_last) begin
                        r_state  <= c_READ_INV;
                        mem_addr <= c_ZERO_ADDR;
                        mem_din  <= '0;
                        mem_wrt  <= 1'b0;
                        mem_rd   <= 1'b1;
                    end else begin
                        mem_addr <= w_addr_inc;
                        mem_din  <= ~f_pat(w_addr_inc);
                    end
                end

                c_READ_INV: begin
                    r_cmp_vld  <= 1'b1;
                    r_cmp_addr <= mem_addr;
                    r_cmp_inv  <= 1'b1;
                    if (w_last) begin
                        r_state <= c_FLUSH;
                        mem_rd  <= 1'b0;
                    end else begin
                        mem_addr <= w_addr_inc;
                    end
                end
`endif

                c_FLUSH: begin
`ifdef RAM_BIST_INV_PASS_EN
                    if (!r_inv) begin
                        r_state  <= c_WRITE_INV;
                        r_inv    <= 1'b1;
                        mem_addr <= c_ZERO_ADDR;
                        mem_din  <= ~f_pat(c_ZERO_ADDR);
                        mem_wrt  <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        r_state <= c_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 7'd0);
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    mem_wrt <= 1'b0;
                    mem_rd  <= 1'b0;
                    mem_din <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_bist                                                  |
// | Description : Self-checking bench for ram_bist with a fault-injecting RAM  |
// |               and a pattern-level result model.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int DEPTH = 32;
    localparam int LIMIT = 400;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_wrt;
    logic       mem_rd;
    logic [7:0] mem_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_addr;
    logic [6:0] err_cnt;

    ram_bist #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wrt   (mem_wrt),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with per-address stuck-at-0 / stuck-at-1 masks applied on read
    logic [7:0] ram [DEPTH];
    logic [7:0] sa0 [DEPTH];
    logic [7:0] sa1 [DEPTH];
    initial mem_dout = 8'h00;
    always @(posedge clk) begin
        if (mem_wrt) ram[mem_addr] <= mem_din;
        if (mem_rd)  mem_dout <= (ram[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input int a);
        return 8'hA5 ^ 8'(a);
    endfunction

    // Expected result: every address in every pass is written with the pattern
    // and read back through the fault masks.
    task automatic model(output int errs, output int faddr);
        logic [7:0] want, seen;
        errs = 0;
        faddr = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                want = (p == 0) ? pat(a) : ~pat(a);
                seen = (want & ~sa0[a]) | sa1[a];
                if (seen != want) begin
                    if (errs == 0) faddr = a;
                    if (errs < 127) errs++;
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            sa0[a] = 8'h00;
            sa1[a] = 8'h00;
        end
    endtask

    int         cycles;
    int         widx;
    int         ridx;
    int         trace_err;
    logic [7:0] din_first;
    logic [7:0] din_last;

    task automatic sample();
        logic [7:0] want;
        if (mem_wrt && mem_rd) trace_err++;
        if (!busy) trace_err++;
        if (mem_wrt) begin
            want = (widx < DEPTH) ? pat(widx % DEPTH) : ~pat(widx % DEPTH);
            if (mem_addr != 5'(widx % DEPTH) || mem_din != want) trace_err++;
            if (widx == 0)  din_first = mem_din;
            if (widx == 31) din_last  = mem_din;
            widx++;
        end else if (mem_rd) begin
            if (mem_addr != 5'(ridx % DEPTH) || mem_din != 8'h00) trace_err++;
            ridx++;
        end else if (mem_din != 8'h00) begin
            trace_err++;
        end
    endtask

    // Leaves the bench 1 ns after the start edge (first write cycle visible)
    task automatic start_run(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        cycles = 0; widx = 0; ridx = 0; trace_err = 0;
        din_first = 8'h00; din_last = 8'h00;
        while (!done && cycles < LIMIT) begin
            sample();
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_run(input string tag);
        int e_err, e_fail;
        model(e_err, e_fail);
        check({tag, "_cycles"}, cycles, 65 * PASSES);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, (e_err == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, err_cnt, e_err);
        check({tag, "_fail_addr"}, fail_addr, e_fail);
        check({tag, "_trace"}, trace_err, 0);
        check({tag, "_writes"}, widx, DEPTH * PASSES);
        check({tag, "_reads"}, ridx, DEPTH * PASSES);
        check({tag, "_din_a0"}, din_first, 8'hA5);
        check({tag, "_din_a31"}, din_last, 8'hBA);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({mem_addr, mem_din, mem_wrt, mem_rd, busy, done, pass, fail_addr, err_cnt});
    endfunction

    initial begin
        int waited;
        rst = 1'b1;
        start = 1'b0;
        clear_faults();
        for (int a = 0; a < DEPTH; a++) ram[a] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 0);

        // Fault-free RAM
        start_run(0);
        check("busy_after_start", busy, 1);
        wait_done();
        check_run("clean");

        // Bit 0 stuck at 0 at address 10
        clear_faults();
        sa0[10] = 8'h01;
        start_run(0);
        wait_done();
        check_run("sa0_a10");

        // Faults at addresses 3 and 20
        clear_faults();
        sa0[3]  = 8'h04;
        sa0[20] = 8'h01;
        start_run(0);
        wait_done();
        check_run("two_faults");

        // Reset in the middle of the read phase
        clear_faults();
        start_run(0);
        waited = 0;
        while (!(mem_rd && mem_addr == 5'd12) && waited < LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reach_read_a12", {mem_rd, mem_addr}, {1'b1, 5'd12});
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", all_outs(), 0);
        @(negedge clk);
        check("mid_reset_held", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("after_mid_reset_idle", all_outs(), 0);
        start_run(0);
        wait_done();
        check_run("post_reset");

        // start held high for the whole run, then restarts from DONE
        sa1[7] = 8'h80;
        start_run(1);
        wait_done();
        check_run("start_held");
        @(posedge clk);
        #1;
        check("restart_done_clear", {busy, done}, 2'b10);
        start = 1'b0;
        wait_done();
        check_run("restart");

        // Random fault maps
        for (int t = 0; t < 6; t++) begin
            int nf, a;
            clear_faults();
            nf = $urandom_range(0, 4);
            for (int k = 0; k < nf; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) sa0[a] = sa0[a] | 8'(1 << $urandom_range(0, 7));
                else                           sa1[a] = sa1[a] | 8'(1 << $urandom_range(0, 7));
            end
            start_run(0);
            wait_done();
            check_run($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
